// File: rtl/key_expand_seq.sv
// Iterative AES key-schedule generator: expands an Nk-word key into 4*(Nr+1)
// words, one per clock, and presents them in encryption and decryption order.
module key_expand_seq #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6,
  parameter int N  = 32 * Nk
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            key,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [128*(Nr+1)-1:0]   word_enc,
  output logic [128*(Nr+1)-1:0]   word_dec
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         r_state;
  logic [IW-1:0]  r_i;
  logic [2:0]     r_c;
  logic [7:0]     r_rcon;
  logic           r_busy;
  logic           r_done;
  logic [31:0]    r_w [NW];

  logic [31:0]    w_prev;
  logic [31:0]    w_back;
  logic [31:0]    w_t;
  logic [31:0]    w_new;

  // r_i never drops below Nk, so both taps stay inside the schedule array.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_t    = '0;
    w_prev = r_w[r_i - IW'(1)];
    w_back = r_w[r_i - IW'(Nk)];
    if (r_c == 3'd0)
      w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (Nk == 8 && r_c == 3'd4)
      w_t = sub_word(w_prev);
    else
      w_t = w_prev;
    w_new = w_back ^ w_t;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_i     <= IW'(Nk);
      r_c     <= '0;
      r_rcon  <= 8'h01;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      // NOTE: the schedule storage is reset too, because an aborted expansion must leave all-zero outputs.
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            for (int k = 0; k < Nk; k++)  r_w[k] <= key[N-1-32*k -: 32];
            for (int k = Nk; k < NW; k++) r_w[k] <= '0;
            r_i     <= IW'(Nk);
            r_c     <= '0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= EXPAND;
          end
        end
        EXPAND: begin
          r_w[r_i] <= w_new;
          r_c      <= (r_c == 3'(Nk - 1)) ? 3'd0 : r_c + 3'd1;
          if (r_c == 3'd0) r_rcon <= xtime(r_rcon);
          r_i <= r_i + IW'(1);
          if (r_i == IW'(NW - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // Decrypt order just reverses whole round keys; word order inside a key is unchanged.
  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign word_enc[128*r +: 128] = {r_w[4*r], r_w[4*r+1], r_w[4*r+2], r_w[4*r+3]};
    assign word_dec[128*r +: 128] = {r_w[4*(Nr-r)], r_w[4*(Nr-r)+1],
                                     r_w[4*(Nr-r)+2], r_w[4*(Nr-r)+3]};
  end

endmodule

// File: tb/tb_key_expand_seq.sv
// Directed bench for key_expand_seq: FIPS-197 vectors for Nk=4/6/8, ignored
// start, asynchronous abort and restart from DONE.
module tb_key_expand_seq;

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KSEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam int           LIMIT = 200;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start4, start6, start8;
  logic [127:0]   key4;
  logic [191:0]   key6;
  logic [255:0]   key8;
  logic           busy4, done4, busy6, done6, busy8, done8;
  logic [1407:0]  enc4, dec4;
  logic [1663:0]  enc6, dec6;
  logic [1919:0]  enc8, dec8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_expand_seq #(.Nk(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .key(key4), .start(start4),
    .busy(busy4), .done(done4), .word_enc(enc4), .word_dec(dec4));
  key_expand_seq #(.Nk(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .key(key6), .start(start6),
    .busy(busy6), .done(done6), .word_enc(enc6), .word_dec(dec6));
  key_expand_seq #(.Nk(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .key(key8), .start(start8),
    .busy(busy8), .done(done8), .word_enc(enc8), .word_dec(dec8));

  // Pulse start for one edge, scramble the key afterwards, count edges to done.
  task automatic run4(input logic [127:0] k, output int n,
                      output logic done_after, output logic busy_after);
    key4 = k; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; key4 = ~k;
    done_after = done4; busy_after = busy4;
    n = 0;
    while (!done4 && n < LIMIT) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done4); end
    total++; if (enc4 !== '0) begin bad++; $display("FAIL reset_enc4 got=%h want=0", enc4[127:0]); end
    total++; if (dec4 !== '0) begin bad++; $display("FAIL reset_dec4 got=%h want=0", dec4[127:0]); end
    total++; if (enc8 !== '0 || done8 !== 1'b0) begin bad++; $display("FAIL reset_nk8 got done=%b want 0 and zero schedule", done8); end
  endtask

  task automatic test_fips128();
    int n; logic da, ba;
    run4(K128, n, da, ba);
    total++; if (ba !== 1'b1) begin bad++; $display("FAIL f128_busy got=%b want=1", ba); end
    total++; if (n !== 40) begin bad++; $display("FAIL f128_latency got=%0d want=40", n); end
    total++; if (enc4[255:128] !== RK1) begin bad++; $display("FAIL f128_w4_7 got=%h want=%h", enc4[255:128], RK1); end
    total++; if (enc4[1407 -: 128] !== RK10) begin bad++; $display("FAIL f128_rk10 got=%h want=%h", enc4[1407 -: 128], RK10); end
    total++; if (dec4[127:0] !== RK10) begin bad++; $display("FAIL f128_dec0 got=%h want=%h", dec4[127:0], RK10); end
    total++; if (dec4[1407 -: 128] !== K128) begin bad++; $display("FAIL f128_dec10 got=%h want=%h", dec4[1407 -: 128], K128); end
    repeat (5) @(posedge clk); #1;
    total++; if (done4 !== 1'b1 || busy4 !== 1'b0 || enc4[1407 -: 128] !== RK10)
      begin bad++; $display("FAIL f128_hold got done=%b busy=%b want done=1 busy=0", done4, busy4); end
  endtask

  task automatic test_nk6_nk8();
    int n;
    key6 = K192; start6 = 1'b1;
    @(posedge clk); #1; start6 = 1'b0; key6 = '0;
    n = 0;
    while (!done6 && n < LIMIT) begin @(posedge clk); #1; n++; end
    total++; if (n !== 46) begin bad++; $display("FAIL nk6_latency got=%0d want=46", n); end
    total++; if (enc6[160 +: 32] !== 32'hfe0c91f7) begin bad++; $display("FAIL nk6_w6 got=%h want=fe0c91f7", enc6[160 +: 32]); end
    total++; if (enc6[1536 +: 32] !== 32'h01002202) begin bad++; $display("FAIL nk6_w51 got=%h want=01002202", enc6[1536 +: 32]); end
    total++; if (dec6[1663 -: 192] !== K192) begin bad++; $display("FAIL nk6_dec_key got=%h want=%h", dec6[1663 -: 192], K192); end

    key8 = K256; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0; key8 = '0;
    n = 0;
    while (!done8 && n < LIMIT) begin @(posedge clk); #1; n++; end
    total++; if (n !== 52) begin bad++; $display("FAIL nk8_latency got=%0d want=52", n); end
    total++; if (enc8[352 +: 32] !== 32'h9ba35411) begin bad++; $display("FAIL nk8_w8 got=%h want=9ba35411", enc8[352 +: 32]); end
    total++; if (enc8[1792 +: 32] !== 32'h706c631e) begin bad++; $display("FAIL nk8_w59 got=%h want=706c631e", enc8[1792 +: 32]); end
  endtask

  task automatic test_ignored_start();
    int n;
    key4 = K128; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    n = 0;
    while (!done4 && n < LIMIT) begin
      @(posedge clk); #1; n++;
      if (n == 10) begin key4 = KSEQ; start4 = 1'b1; end
      else start4 = 1'b0;
    end
    start4 = 1'b0;
    total++; if (n !== 40) begin bad++; $display("FAIL ign_latency got=%0d want=40", n); end
    total++; if (enc4[1407 -: 128] !== RK10) begin bad++; $display("FAIL ign_rk10 got=%h want=%h", enc4[1407 -: 128], RK10); end
    total++; if (enc4[255:0] !== {RK1, K128}) begin bad++; $display("FAIL ign_rk01 got=%h want=%h", enc4[255:0], {RK1, K128}); end
  endtask

  task automatic test_reset_mid();
    int n; logic da, ba;
    key4 = K128; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got=%b want=1", busy4); end
    rst_n = 1'b0;
    #1;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin bad++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy4, done4); end
    total++; if (enc4 !== '0 || dec4 !== '0) begin bad++; $display("FAIL abort_words got=%h want=0", enc4[255:0]); end
    total++; if (enc6 !== '0 || done6 !== 1'b0) begin bad++; $display("FAIL abort_nk6 got done=%b want 0 and zero schedule", done6); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run4(K128, n, da, ba);
    total++; if (n !== 40) begin bad++; $display("FAIL restart_latency got=%0d want=40", n); end
    total++; if (enc4[1407 -: 128] !== RK10) begin bad++; $display("FAIL restart_rk10 got=%h want=%h", enc4[1407 -: 128], RK10); end
  endtask

  task automatic test_back_to_back();
    int n; logic da, ba;
    run4(KSEQ, n, da, ba);
    total++; if (da !== 1'b0 || ba !== 1'b1) begin bad++; $display("FAIL b2b_drop got done=%b busy=%b want 0 1", da, ba); end
    total++; if (n !== 40) begin bad++; $display("FAIL b2b_latency got=%0d want=40", n); end
    total++; if (enc4[1407 -: 128] !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
      begin bad++; $display("FAIL b2b_rk10 got=%h want=13111d7fe3944a17f307a78b4d2b30c5", enc4[1407 -: 128]); end
    total++; if (enc4[255:128] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe)
      begin bad++; $display("FAIL b2b_rk1 got=%h want=d6aa74fdd2af72fadaa678f1d6ab76fe", enc4[255:128]); end
    total++; if (dec4[1407 -: 128] !== KSEQ) begin bad++; $display("FAIL b2b_dec10 got=%h want=%h", dec4[1407 -: 128], KSEQ); end
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_fips128();
    test_nk6_nk8();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
